// File: rtl/fp_mul_iter.sv
// fp_mul_iter: multi-cycle IEEE-754 binary floating-point multiplier.
// The significand product is built with radix-4 Booth recoding, one partial
// product per clock into a single accumulator. Rounding is round-to-nearest-even.
// Subnormal inputs are treated as zero (DAZ) and subnormal results are flushed
// to zero (FTZ).
//
// Optional feature macro: FP_MUL_ITER_FLAGS_EN
//   defined   -> out_flags carries {invalid, overflow, underflow, inexact}
//   undefined -> out_flags is tied to zero and no flag logic is built
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   in_valid   operand pair valid
//   in_ready   block can accept operands (high only in IDLE)
//   in_a/in_b  operands {sign, exp, frac}
//   out_valid  result valid (held until out_ready)
//   out_ready  consumer accepts result
//   out_data   product {sign, exp, frac}
//   out_flags  {invalid, overflow, underflow, inexact}
module fp_mul_iter #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] in_a,
    input  logic [EXP_W+MAN_W:0] in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] out_data,
    output logic [3:0]           out_flags
);
    localparam int SIG_W = MAN_W + 1;
    localparam int ITER  = (MAN_W + 3) / 2;
    localparam int ACC_W = 2 * SIG_W + 2;
    localparam int BX_W  = 2 * ITER + 1;
    localparam int CNT_W = $clog2(ITER + 1);
    localparam int DW    = EXP_W + MAN_W + 1;

    localparam logic [EXP_W+1:0] BIAS     = (EXP_W+2)'((1 << (EXP_W - 1)) - 1);
    localparam logic [EXP_W+1:0] EXP_MAX  = {2'b00, {EXP_W{1'b1}}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);
    localparam logic [ACC_W-1:0] ACC_ONE  = {{(ACC_W-1){1'b0}}, 1'b1};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_NORM = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Operand field decode (combinational, consumed only on the accepting edge)
    logic [EXP_W-1:0] w_a_e, w_b_e;
    logic [MAN_W-1:0] w_a_f, w_b_f;
    logic             w_a_zero, w_a_inf, w_a_nan;
    logic             w_b_zero, w_b_inf, w_b_nan;
    logic             w_inf_x_zero, w_nan_out;
    logic [EXP_W+1:0] w_exp_raw;

    assign w_a_e        = in_a[DW-2:MAN_W];
    assign w_b_e        = in_b[DW-2:MAN_W];
    assign w_a_f        = in_a[MAN_W-1:0];
    assign w_b_f        = in_b[MAN_W-1:0];
    assign w_a_zero     = (w_a_e == {EXP_W{1'b0}});
    assign w_b_zero     = (w_b_e == {EXP_W{1'b0}});
    assign w_a_inf      = (w_a_e == {EXP_W{1'b1}}) && (w_a_f == {MAN_W{1'b0}});
    assign w_b_inf      = (w_b_e == {EXP_W{1'b1}}) && (w_b_f == {MAN_W{1'b0}});
    assign w_a_nan      = (w_a_e == {EXP_W{1'b1}}) && (w_a_f != {MAN_W{1'b0}});
    assign w_b_nan      = (w_b_e == {EXP_W{1'b1}}) && (w_b_f != {MAN_W{1'b0}});
    assign w_inf_x_zero = (w_a_inf & w_b_zero) | (w_b_inf & w_a_zero);
    assign w_nan_out    = w_a_nan | w_b_nan | w_inf_x_zero;
    // Two guard bits above the field keep the biased sum signed-safe.
    assign w_exp_raw    = {2'b00, w_a_e} + {2'b00, w_b_e} - BIAS;

`ifdef FP_MUL_ITER_FLAGS_EN
    logic w_invalid;
    // A NaN whose fraction MSB is clear is signalling.
    assign w_invalid = (w_a_nan & ~w_a_f[MAN_W-1]) | (w_b_nan & ~w_b_f[MAN_W-1]) | w_inf_x_zero;
    logic       r_invalid;
    logic [3:0] r_flags;
    logic [3:0] w_res_flags;
`endif

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sign, r_is_nan, r_is_inf, r_is_zero;
    logic [EXP_W+1:0] r_exp;
    logic [SIG_W-1:0] r_sig_a;
    logic [BX_W-1:0]  r_bx;
    logic [ACC_W-1:0] r_acc;
    logic             r_in_ready, r_out_valid;
    logic [DW-1:0]    r_out_data;

    // Booth partial-product selection from the top triplet of the multiplier
    logic [ACC_W-1:0] w_a1, w_a2, w_pp;
    assign w_a1 = {{(ACC_W-SIG_W){1'b0}}, r_sig_a};
    assign w_a2 = {w_a1[ACC_W-2:0], 1'b0};
    always_comb begin
        w_pp = {ACC_W{1'b0}};
        case (r_bx[BX_W-1 -: 3])
            3'b001, 3'b010: w_pp = w_a1;
            3'b011:         w_pp = w_a2;
            3'b100:         w_pp = ~w_a2 + ACC_ONE;
            3'b101, 3'b110: w_pp = ~w_a1 + ACC_ONE;
            default:        w_pp = {ACC_W{1'b0}};
        endcase
    end

    // Normalisation, RNE rounding and special-case resolution of the product
    logic             w_norm, w_guard, w_sticky, w_rnd_up, w_carry, w_ovf, w_unf;
    logic [SIG_W-1:0] w_mant;
    logic [SIG_W:0]   w_mant_r;
    logic [MAN_W-1:0] w_frac;
    logic [EXP_W+1:0] w_exp_f;
    logic [DW-1:0]    w_res_data;
    always_comb begin
        // The bits above 2*SIG_W-1 are always zero for an unsigned product.
        w_norm = |r_acc[ACC_W-1:2*SIG_W-1];
        if (w_norm) begin
            w_mant   = r_acc[2*SIG_W-1:SIG_W];
            w_guard  = r_acc[SIG_W-1];
            w_sticky = |r_acc[SIG_W-2:0];
        end else begin
            w_mant   = r_acc[2*SIG_W-2:SIG_W-1];
            w_guard  = r_acc[SIG_W-2];
            w_sticky = |r_acc[SIG_W-3:0];
        end
        w_rnd_up = w_guard & (w_sticky | w_mant[0]);
        w_mant_r = {1'b0, w_mant} + {{SIG_W{1'b0}}, w_rnd_up};
        w_carry  = w_mant_r[SIG_W];
        if (w_carry) begin
            w_frac = w_mant_r[MAN_W:1];
        end else begin
            w_frac = w_mant_r[MAN_W-1:0];
        end
        w_exp_f = r_exp + {{(EXP_W+1){1'b0}}, w_norm} + {{(EXP_W+1){1'b0}}, w_carry};
        w_ovf   = ~w_exp_f[EXP_W+1] & (w_exp_f >= EXP_MAX);
        w_unf   = w_exp_f[EXP_W+1] | (w_exp_f == {(EXP_W+2){1'b0}});
`ifdef FP_MUL_ITER_FLAGS_EN
        w_res_flags = 4'b0000;
`endif
        if (r_is_nan) begin
            w_res_data = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
`ifdef FP_MUL_ITER_FLAGS_EN
            w_res_flags = {r_invalid, 3'b000};
`endif
        end else if (r_is_inf) begin
            w_res_data = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (r_is_zero) begin
            w_res_data = {r_sign, {(EXP_W+MAN_W){1'b0}}};
        end else if (w_ovf) begin
            w_res_data = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`ifdef FP_MUL_ITER_FLAGS_EN
            w_res_flags = 4'b0101;
`endif
        end else if (w_unf) begin
            w_res_data = {r_sign, {(EXP_W+MAN_W){1'b0}}};
`ifdef FP_MUL_ITER_FLAGS_EN
            w_res_flags = 4'b0011;
`endif
        end else begin
            w_res_data = {r_sign, w_exp_f[EXP_W-1:0], w_frac};
`ifdef FP_MUL_ITER_FLAGS_EN
            w_res_flags = {3'b000, w_guard | w_sticky};
`endif
        end
    end

    // Control FSM, operand capture, Booth accumulation and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= {CNT_W{1'b0}};
            r_sign      <= 1'b0;
            r_is_nan    <= 1'b0;
            r_is_inf    <= 1'b0;
            r_is_zero   <= 1'b0;
            r_exp       <= {(EXP_W+2){1'b0}};
            r_sig_a     <= {SIG_W{1'b0}};
            r_bx        <= {BX_W{1'b0}};
            r_acc       <= {ACC_W{1'b0}};
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= {DW{1'b0}};
`ifdef FP_MUL_ITER_FLAGS_EN
            r_invalid   <= 1'b0;
            r_flags     <= 4'b0000;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_sign     <= in_a[DW-1] ^ in_b[DW-1];
                        r_exp      <= w_exp_raw;
                        r_is_nan   <= w_nan_out;
                        r_is_inf   <= w_a_inf | w_b_inf;
                        r_is_zero  <= w_a_zero | w_b_zero;
                        r_sig_a    <= {~w_a_zero, w_a_f};
                        // Multiplier zero-extended on top, implicit b[-1]=0 below.
                        r_bx       <= {{(BX_W-SIG_W-1){1'b0}}, ~w_b_zero, w_b_f, 1'b0};
                        r_acc      <= {ACC_W{1'b0}};
                        r_cnt      <= CNT_LAST;
                        r_in_ready <= 1'b0;
                        r_state    <= S_MUL;
`ifdef FP_MUL_ITER_FLAGS_EN
                        r_invalid  <= w_invalid;
`endif
                    end
                end
                S_MUL: begin
                    // MSB-first: left shifts wrap modulo 2^ACC_W, so negative
                    // intermediate sums resolve exactly in the final product.
                    r_acc <= {r_acc[ACC_W-3:0], 2'b00} + w_pp;
                    r_bx  <= {r_bx[BX_W-3:0], 2'b00};
                    if (r_cnt == {CNT_W{1'b0}}) begin
                        r_state <= S_NORM;
                    end else begin
                        r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                S_NORM: begin
                    r_out_data <= w_res_data;
`ifdef FP_MUL_ITER_FLAGS_EN
                    r_flags    <= w_res_flags;
`endif
                    r_state    <= S_DONE;
                end
                S_DONE: begin
                    // out_valid rises one cycle into DONE; out_ready before that is ignored.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
`ifdef FP_MUL_ITER_FLAGS_EN
    assign out_flags = r_flags;
`else
    assign out_flags = 4'b0000;
`endif

endmodule

// File: tb/tb_fp_mul_iter.sv
// Bench for fp_mul_iter (binary32). A behavioural model computes each product
// with plain integer arithmetic; a negedge monitor compares every valid output
// against a queue of expected results, and directed vectors pin the model.
module tb_fp_mul_iter;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a, in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_flags;

`ifdef FP_MUL_ITER_FLAGS_EN
    localparam logic [3:0] FLAG_MASK = 4'hF;
`else
    localparam logic [3:0] FLAG_MASK = 4'h0;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [35:0] exp_q[$];

    fp_mul_iter dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_flags(out_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Returns {flags, data}; flags are {invalid, overflow, underflow, inexact}.
    function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b);
        logic s;
        int ea, eb, e, sh;
        logic [22:0] fa, fb;
        bit az, ai, an, bz, bi, bn, inv;
        longint p, m, rem, half;
        logic [3:0] f;
        logic [31:0] d;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]); eb = int'(b[30:23]);
        fa = a[22:0]; fb = b[22:0];
        az = (ea == 0); bz = (eb == 0);
        ai = (ea == 255) && (fa == 23'h0); bi = (eb == 255) && (fb == 23'h0);
        an = (ea == 255) && (fa != 23'h0); bn = (eb == 255) && (fb != 23'h0);
        inv = (an && !fa[22]) || (bn && !fb[22]) || (ai && bz) || (bi && az);
        f = 4'b0000;
        if (an || bn || (ai && bz) || (bi && az)) begin
            d = 32'h7FC0_0000;
            f = {inv, 3'b000};
        end else if (ai || bi) begin
            d = {s, 8'hFF, 23'h0};
        end else if (az || bz) begin
            d = {s, 31'h0};
        end else begin
            p  = longint'({1'b1, fa}) * longint'({1'b1, fb});
            e  = ea + eb - 127;
            sh = (p >= 64'h8000_0000_0000) ? 24 : 23;
            if (sh == 24) e++;
            m    = p >> sh;
            rem  = p - (m << sh);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && m[0])) m++;
            if (m == (64'd1 << 24)) begin
                m = 64'd1 << 23;
                e++;
            end
            if (e >= 255) begin
                d = {s, 8'hFF, 23'h0};
                f = 4'b0101;
            end else if (e <= 0) begin
                d = {s, 31'h0};
                f = 4'b0011;
            end else begin
                d = {s, 8'(e), m[22:0]};
                f = {3'b000, rem != 0};
            end
        end
        return {f & FLAG_MASK, d};
    endfunction

    // Output monitor: every valid cycle must match the oldest outstanding result.
    always @(negedge clk) begin
        if (rst === 1'b0 && out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL spurious_valid: got data 0x%0h with no operation outstanding", out_data);
            end else begin
                chk("out_data", out_data, exp_q[0][31:0]);
                chk("out_flags", {28'h0, out_flags}, {28'h0, exp_q[0][35:32]});
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] lit_d, input logic [3:0] lit_f,
                          input int hold, input bit pulse);
        logic [35:0] m;
        int lat;
        bit got;
        m = model(a, b);
        chk("model_pin_data", m[31:0], lit_d);
        chk("model_pin_flags", {28'h0, m[35:32]}, {28'h0, lit_f & FLAG_MASK});
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (in_ready === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!got) begin
            chk("in_ready_wait_timeout", {31'h0, in_ready}, 32'h1);
            return;
        end
        in_a = a; in_b = b; in_valid = 1'b1;
        out_ready = (hold == 0);
        exp_q.push_back(m);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0; got = 1'b0;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (pulse && (lat == 3 || lat == 4 || lat == 8)) begin
                in_valid = 1'b1; in_a = 32'h7F80_0000; in_b = 32'h0000_0000;
            end else begin
                in_valid = 1'b0;
            end
            if (out_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
            chk("in_ready_busy", {31'h0, in_ready}, 32'h0);
        end
        if (!got) begin
            chk("out_valid_timeout", {31'h0, out_valid}, 32'h1);
            return;
        end
        chk("latency", lat, 32'd15);
        chk("in_ready_at_valid", {31'h0, in_ready}, 32'h0);
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                chk("hold_out_valid", {31'h0, out_valid}, 32'h1);
                chk("hold_in_ready", {31'h0, in_ready}, 32'h0);
            end
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk("post_out_valid", {31'h0, out_valid}, 32'h0);
        chk("post_in_ready", {31'h0, in_ready}, 32'h1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_a = 32'h0; in_b = 32'h0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", {31'h0, in_ready}, 32'h1);
        chk("reset_out_valid", {31'h0, out_valid}, 32'h0);
        chk("reset_out_data", out_data, 32'h0);
        chk("reset_out_flags", {28'h0, out_flags}, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 4'b0000, 0, 1'b0);
        run_op(32'h3FC0_0000, 32'hBFC0_0000, 32'hC010_0000, 4'b0000, 6, 1'b1);
        run_op(32'h3F80_0001, 32'h3FC0_0000, 32'h3FC0_0002, 4'b0001, 0, 1'b0);
        run_op(32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000, 4'b0101, 0, 1'b0);
        run_op(32'h0080_0000, 32'h3F00_0000, 32'h0000_0000, 4'b0011, 0, 1'b0);
        run_op(32'h7F80_0000, 32'h8000_0000, 32'h7FC0_0000, 4'b1000, 0, 1'b0);
        run_op(32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 4'b0000, 0, 1'b0);
        run_op(32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000, 4'b0000, 0, 1'b0);
        run_op(32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000, 4'b1000, 0, 1'b0);
        run_op(32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 4'b0000, 0, 1'b0);
        run_op(32'h0000_0001, 32'h4000_0000, 32'h0000_0000, 4'b0000, 0, 1'b0);

        // Abort an operation mid-multiply; nothing may come out for it.
        in_a = 32'h4040_0000; in_b = 32'h4040_0000; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_out_valid", {31'h0, out_valid}, 32'h0);
        chk("abort_in_ready", {31'h0, in_ready}, 32'h1);
        run_op(32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 4'b0000, 0, 1'b0);

        repeat (20) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
